// File: rtl/poll_div_pkg.sv
// Shared operand width, FSM state type and counter width for the
// restoring divider that decomposes MAC results.
package Pollparametr;

    localparam int Const     = 8;
    localparam int DIV_CNT_W = $clog2(2*Const);

    typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;

endpackage

// File: rtl/poll_div_step.sv
// One restoring-division step: shift in the next dividend bit, then
// subtract the divisor when it fits.
module poll_div_step
    import Pollparametr::*;
(
    input  logic [Const:0]   rem,
    input  logic             din_bit,
    input  logic [Const-1:0] b,
    output logic [Const:0]   rem_next,
    output logic             q_bit
);

    // One spare bit so the comparison never loses the shifted-out MSB.
    logic [Const+1:0] shifted;

    always_comb begin
        shifted = {rem, din_bit};
        if (shifted >= {2'b00, b}) begin
            rem_next = (Const+1)'(shifted - {2'b00, b});
            q_bit    = 1'b1;
        end else begin
            rem_next = shifted[Const:0];
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/poll_div.sv
// Sequential restoring divider: recovers A and C from DATA_IN = A*B + C,
// one quotient bit per clock, with valid/ready handshakes on both sides.
module poll_div
    import Pollparametr::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*Const-1:0] DATA_IN,
    input  logic [Const-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*Const-1:0] Q,
    output logic [Const-1:0]   R,
    output logic               ovf,
    output logic               div_zero
);

    localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(2*Const-1);

    div_state_t             state_q, state_d;
    logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
    logic [Const:0]         rem_q, rem_d;
    logic [2*Const-1:0]     dvd_q, dvd_d;
    logic [Const-1:0]       b_q, b_d;
    logic [2*Const-1:0]     q_q, q_d;
    logic [Const-1:0]       r_q, r_d;
    logic                   ovf_q, ovf_d;
    logic                   dz_q, dz_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q, in_ready_d;

    logic [Const:0]         step_rem;
    logic                   step_q;
    logic [2*Const-1:0]     q_final;

    poll_div_step u_step (
        .rem      (rem_q),
        .din_bit  (dvd_q[2*Const-1]),
        .b        (b_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // The dividend register doubles as the quotient register: each step
    // consumes its MSB and shifts the new quotient bit into its LSB.
    assign q_final = {dvd_q[2*Const-2:0], step_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        b_d         = b_q;
        q_d         = q_q;
        r_d         = r_q;
        ovf_d       = ovf_q;
        dz_d        = dz_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            DIV_IDLE: begin
                if (in_valid) begin
                    in_ready_d = 1'b0;
                    b_d        = B;
                    if (B != '0) begin
                        state_d = DIV_CALC;
                        cnt_d   = '0;
                        rem_d   = '0;
                        dvd_d   = DATA_IN;
                    end else begin
                        state_d     = DIV_DONE;
                        q_d         = '1;
                        r_d         = DATA_IN[Const-1:0];
                        dz_d        = 1'b1;
                        ovf_d       = 1'b1;
                        out_valid_d = 1'b1;
                    end
                end
            end
            DIV_CALC: begin
                rem_d = step_rem;
                dvd_d = q_final;
                cnt_d = cnt_q + DIV_CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d     = DIV_DONE;
                    q_d         = q_final;
                    r_d         = step_rem[Const-1:0];
                    ovf_d       = |q_final[2*Const-1:Const];
                    dz_d        = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            DIV_DONE: begin
                if (out_ready) begin
                    state_d     = DIV_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = DIV_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= DIV_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            b_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            b_q         <= b_d;
            q_q         <= q_d;
            r_q         <= r_d;
            ovf_q       <= ovf_d;
            dz_q        <= dz_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Q         = q_q;
    assign R         = r_q;
    assign ovf       = ovf_q;
    assign div_zero  = dz_q;

endmodule
